// File: rtl/spi_transfer_sequencer_if.sv
// Host-side byte interface of the SPI transfer sequencer: transaction start,
// TX byte stream (valid/ready) and RX byte pulse.
`timescale 1ns/1ps
interface spi_transfer_sequencer_if;
  logic       i_start;
  logic [7:0] i_divisor;
  logic [7:0] i_len;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_start, i_divisor, i_len, i_tx_data, i_tx_valid,
    input  o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_divisor, i_len, i_tx_data, i_tx_valid,
    output o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_done
  );
endinterface

// File: rtl/spi_transfer_sequencer.sv
// Mode-0 MSB-first SPI master sequencer: configures an external clock divider,
// launches one 8-SCLK burst per byte and shifts MOSI/MISO around its edges.
`timescale 1ns/1ps
module spi_transfer_sequencer #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  spi_transfer_sequencer_if.slave     host,
  output logic [8:0]                  o_div_config,
  output logic                        o_div_start_n,
  input  logic                        i_div_ready,
  input  logic                        i_div_clk,
  output logic                        o_sclk,
  output logic                        o_mosi,
  input  logic                        i_miso,
  output logic                        o_cs_n
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CFG_GAP, S_CS_SETUP, S_WAIT_TX,
    S_LAUNCH, S_SHIFT, S_BYTE_DONE, S_CS_HOLD, S_DONE
  } state_t;

  state_t     r_state;
  logic       r_div_clk_q;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [7:0] r_rx_data;
  logic [8:0] r_div_config;
  logic       r_start_n;
  logic       r_cs_n;
  logic       r_tx_ready;
  logic       r_rx_valid;
  logic       r_busy;
  logic       r_done;

  logic       w_rise;
  logic       w_fall;
  logic [7:0] w_div_clamped;

  assign w_rise        = i_div_clk & ~r_div_clk_q;
  assign w_fall        = ~i_div_clk & r_div_clk_q;
  assign w_div_clamped = (host.i_divisor < 8'd2) ? 8'd2 : host.i_divisor;

  assign o_sclk          = i_div_clk;
  assign o_mosi          = r_tx_sr[7];
  assign o_cs_n          = r_cs_n;
  assign o_div_start_n   = r_start_n;
  assign o_div_config    = r_div_config;
  assign host.o_tx_ready = r_tx_ready;
  assign host.o_rx_data  = r_rx_data;
  assign host.o_rx_valid = r_rx_valid;
  assign host.o_busy     = r_busy;
  assign host.o_done     = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_div_clk_q  <= 1'b0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
      r_rx_data    <= '0;
      r_div_config <= '0;
      r_start_n    <= 1'b1;
      r_cs_n       <= 1'b1;
      r_tx_ready   <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_div_clk_q <= i_div_clk;
      r_rx_valid  <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (host.i_start && host.i_len != 8'd0) begin
            r_len        <= host.i_len;
            r_div_config <= {w_div_clamped, 1'b1};
            r_busy       <= 1'b1;
            r_state      <= S_CFG;
          end
        end
        S_CFG: begin
          r_div_config <= '0;
          r_state      <= S_CFG_GAP;
        end
        S_CFG_GAP: begin
          r_cs_n  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_CS_SETUP;
        end
        S_CS_SETUP: begin
          if (r_cnt == 8'(CS_SETUP - 1)) begin
            r_tx_ready <= 1'b1;
            r_state    <= S_WAIT_TX;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT_TX: begin
          // MOSI is the shift register MSB, so bit 7 is on the wire before the burst.
          if (host.i_tx_valid) begin
            r_tx_ready <= 1'b0;
            r_tx_sr    <= host.i_tx_data;
            r_bit_cnt  <= '0;
            r_start_n  <= 1'b0;
            r_state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (!i_div_ready) begin
            r_start_n <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_rise) begin
            r_rx_sr   <= {r_rx_sr[6:0], i_miso};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          // The eighth fall sees bit_cnt==8, so MOSI keeps the last bit.
          if (w_fall && r_bit_cnt < 4'd8)
            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
          if (i_div_ready)
            r_state <= S_BYTE_DONE;
        end
        S_BYTE_DONE: begin
          r_rx_data  <= r_rx_sr;
          r_rx_valid <= 1'b1;
          r_len      <= r_len - 8'd1;
          if (r_len > 8'd1) begin
            r_tx_ready <= 1'b1;
            r_state    <= S_WAIT_TX;
          end else begin
            r_cnt   <= '0;
            r_state <= S_CS_HOLD;
          end
        end
        S_CS_HOLD: begin
          if (r_cnt == 8'(CS_HOLD - 1)) begin
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transfer_sequencer.sv
// Bench for spi_transfer_sequencer: behavioural divider and SPI slave, bus
// monitors, and per-transaction scoreboard against expected byte streams.
`timescale 1ns/1ps
module tb_spi_transfer_sequencer;
  localparam int CLK_NS = 10;
  localparam int M_SLAVE = 0, M_LOOP = 1, M_ONES = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_transfer_sequencer_if hif();
  logic [8:0] div_config;
  logic       div_start_n, div_ready, div_clk, sclk, mosi, miso, cs_n;

  spi_transfer_sequencer #(.CS_SETUP(2), .CS_HOLD(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .host(hif),
    .o_div_config(div_config), .o_div_start_n(div_start_n),
    .i_div_ready(div_ready), .i_div_clk(div_clk),
    .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso), .o_cs_n(cs_n)
  );

  // Divider: 8 SCLK periods of dv_div cycles each, low half first, idles low.
  int dv_div, dv_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_div <= 2; dv_n <= 0; div_ready <= 1'b1; div_clk <= 1'b0;
    end else begin
      if (div_config[0]) dv_div <= int'(div_config[8:1]);
      if (div_ready) begin
        if (!div_start_n) begin div_ready <= 1'b0; dv_n <= 0; end
      end else if (dv_n == 8 * dv_div) begin
        div_ready <= 1'b1; div_clk <= 1'b0;
      end else begin
        div_clk <= ((dv_n % dv_div) >= (dv_div - dv_div / 2));
        dv_n    <= dv_n + 1;
      end
    end
  end

  // SPI slave: presents sl_mem bytes MSB-first, changing on SCLK fall.
  int         miso_mode = M_SLAVE;
  logic [7:0] sl_mem [256];
  int         sl_byte = 0, sl_bit = 0;
  logic [7:0] sl_cur;
  always @(negedge sclk or posedge cs_n) begin
    if (cs_n) begin sl_byte <= 0; sl_bit <= 0; end
    else if (sl_bit == 7) begin sl_bit <= 0; sl_byte <= sl_byte + 1; end
    else sl_bit <= sl_bit + 1;
  end
  assign sl_cur = sl_mem[sl_byte[7:0]];
  assign miso = (miso_mode == M_LOOP) ? mosi :
                (miso_mode == M_ONES) ? 1'b1 : sl_cur[3'(7 - sl_bit)];

  // Bus monitors
  int         cfg_cnt = 0, done_cnt = 0, done_cs_bad = 0, rise_cnt = 0;
  int         sp_err = 0, cs_err = 0, cs_rise = 0, nbit = 0;
  logic [8:0] cfg_last = '0;
  logic [7:0] msh = '0;
  logic       sclk_q = 1'b0, cs_q = 1'b1;
  longint     last_rise = 0, exp_period = 40;
  logic [7:0] rx_q[$];
  logic [7:0] mosi_q[$];

  always @(negedge clk) begin
    sclk_q <= sclk;
    cs_q   <= cs_n;
    if (cs_n && !cs_q) cs_rise <= cs_rise + 1;
    if (div_config != 9'd0) begin cfg_cnt <= cfg_cnt + 1; cfg_last <= div_config; end
    if (hif.o_done) begin
      done_cnt <= done_cnt + 1;
      if (!cs_n) done_cs_bad <= done_cs_bad + 1;
    end
    if (hif.o_rx_valid) rx_q.push_back(hif.o_rx_data);
    if (sclk && !sclk_q) begin
      if (cs_n) cs_err <= cs_err + 1;
      if (nbit != 0 && ($time - last_rise) != exp_period) sp_err <= sp_err + 1;
      last_rise <= $time;
      rise_cnt  <= rise_cnt + 1;
      msh       <= {msh[6:0], mosi};
      if (nbit == 7) begin mosi_q.push_back({msh[6:0], mosi}); nbit <= 0; end
      else nbit <= nbit + 1;
    end else if (cs_n) begin
      nbit <= 0;
    end
  end

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int div, input int len);
    hif.i_divisor = 8'(div); hif.i_len = 8'(len); hif.i_start = 1'b1;
    @(negedge clk);
    hif.i_start = 1'b0;
  endtask

  // Called at a negedge; waits for o_tx_ready, optionally stalls, then hands over d.
  task automatic send_byte(input logic [7:0] d, input int gap);
    int t = 0, bad = 0;
    while (!hif.o_tx_ready && t < 6000) begin @(negedge clk); t++; end
    check("tx_ready_timeout", 32'(t < 6000), 32'd1);
    if (gap > 0) begin
      repeat (gap) begin
        @(negedge clk);
        if (sclk || cs_n || !hif.o_tx_ready) bad++;
      end
      check("gap_idle", bad, 0);
    end
    hif.i_tx_data = d; hif.i_tx_valid = 1'b1;
    @(negedge clk);
    hif.i_tx_valid = 1'b0;
  endtask

  logic [7:0] txq[$];

  task automatic run_xfer(input int div, input int len, input int mode,
                          input int gap_at, input int gap_cyc, input bit poke);
    int rx0 = rx_q.size(), mo0 = mosi_q.size(), r0 = rise_cnt, d0 = done_cnt;
    int c0 = cfg_cnt, sp0 = sp_err, cs0 = cs_err, cr0 = cs_rise, db0 = done_cs_bad;
    int cd = (div < 2) ? 2 : div;
    int t = 0;
    logic [7:0] tx[$];
    logic [7:0] ex;
    for (int k = 0; k < len; k++) begin
      tx.push_back((k < txq.size()) ? txq[k] : 8'($urandom));
      sl_mem[k] = 8'($urandom);
    end
    txq.delete();
    exp_period = longint'(cd * CLK_NS);
    miso_mode  = mode;
    @(negedge clk);
    pulse_start(div, len);
    check("busy_after_start", 32'(hif.o_busy), 32'd1);
    for (int k = 0; k < len; k++) begin
      send_byte(tx[k], (k == gap_at) ? gap_cyc : 0);
      if (poke && k == 0) pulse_start(9, 5);
    end
    while (done_cnt == d0 && t < 6000) begin @(negedge clk); t++; end
    check("done_timeout", 32'(t < 6000), 32'd1);
    repeat (4) @(negedge clk);
    check("busy_end", 32'(hif.o_busy), 32'd0);
    check("cs_end", 32'(cs_n), 32'd1);
    check("done_pulses", done_cnt - d0, 1);
    check("done_cs_high", done_cs_bad - db0, 0);
    check("cfg_pulses", cfg_cnt - c0, 1);
    check("cfg_value", 32'(cfg_last), 32'({8'(cd), 1'b1}));
    check("sclk_rises", rise_cnt - r0, 8 * len);
    check("sclk_spacing", sp_err - sp0, 0);
    check("rise_cs_high", cs_err - cs0, 0);
    check("cs_deasserts", cs_rise - cr0, 1);
    check("rx_count", rx_q.size() - rx0, len);
    check("mosi_count", mosi_q.size() - mo0, len);
    if (rx_q.size() - rx0 == len && mosi_q.size() - mo0 == len) begin
      for (int k = 0; k < len; k++) begin
        ex = (mode == M_LOOP) ? tx[k] : (mode == M_ONES) ? 8'hFF : sl_mem[k];
        check("rx_byte", 32'(rx_q[rx0 + k]), 32'(ex));
        check("mosi_byte", 32'(mosi_q[mo0 + k]), 32'(tx[k]));
      end
    end
  endtask

  initial begin
    int t, d0, c0, r0;
    hif.i_start = 1'b0; hif.i_divisor = 8'd0; hif.i_len = 8'd0;
    hif.i_tx_data = 8'd0; hif.i_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_start_n", 32'(div_start_n), 32'd1);
    check("rst_config", 32'(div_config), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_ready", 32'(hif.o_tx_ready), 32'd0);
    check("rst_rx_valid", 32'(hif.o_rx_valid), 32'd0);
    check("rst_rx_data", 32'(hif.o_rx_data), 32'd0);
    check("rst_busy", 32'(hif.o_busy), 32'd0);
    check("rst_done", 32'(hif.o_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    txq = '{8'hA5};
    run_xfer(4, 1, M_LOOP, -1, 0, 1'b0);
    txq = '{8'h01, 8'h80, 8'hFF};
    run_xfer(2, 3, M_ONES, -1, 0, 1'b0);
    run_xfer(250, 2, M_SLAVE, 1, 50, 1'b0);

    // Zero-length start is ignored
    d0 = done_cnt; c0 = cfg_cnt;
    @(negedge clk);
    pulse_start(4, 0);
    check("len0_busy", 32'(hif.o_busy), 32'd0);
    repeat (10) @(negedge clk);
    check("len0_busy_late", 32'(hif.o_busy), 32'd0);
    check("len0_done", done_cnt - d0, 0);
    check("len0_cfg", cfg_cnt - c0, 0);

    run_xfer(4, 2, M_SLAVE, -1, 0, 1'b1);
    run_xfer(0, 2, M_SLAVE, -1, 0, 1'b0);
    run_xfer(1, 1, M_LOOP, -1, 0, 1'b0);
    repeat (6) run_xfer(int'($urandom_range(2, 12)), int'($urandom_range(1, 4)),
                        int'($urandom_range(0, 2)), -1, 0, 1'b0);

    // Reset during the second byte of a 3-byte transfer
    miso_mode = M_LOOP; exp_period = 40; r0 = rise_cnt;
    @(negedge clk);
    pulse_start(4, 3);
    send_byte(8'($urandom), 0);
    send_byte(8'($urandom), 0);
    t = 0;
    while (rise_cnt - r0 < 11 && t < 3000) begin @(negedge clk); t++; end
    check("midshift_timeout", 32'(t < 3000), 32'd1);
    check("midshift_cs_low", 32'(cs_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_busy", 32'(hif.o_busy), 32'd0);
    check("arst_start_n", 32'(div_start_n), 32'd1);
    check("arst_tx_ready", 32'(hif.o_tx_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(hif.o_busy), 32'd0);
    check("post_rst_sclk", 32'(sclk), 32'd0);
    run_xfer(4, 2, M_SLAVE, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
